// File: rtl/multi_config_counter.sv
// Multi-channel credit/occupancy counter with per-channel saturation limits.
// Supports conditional decrement and sticky overflow/underflow flags.
module multi_config_counter #(
  parameter int count_sz = 10,
  parameter int num_ch   = 4,
  parameter int ch_sz    = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                increment__ENA,
  input  logic [ch_sz-1:0]    increment_ch,
  input  logic [count_sz-1:0] increment_v,
  output logic                increment__RDY,
  input  logic                decrement__ENA,
  input  logic [ch_sz-1:0]    decrement_ch,
  input  logic [count_sz-1:0] decrement_v,
  output logic                decrement__RDY,
  input  logic                maybeDecrement__ENA,
  input  logic [ch_sz-1:0]    maybeDecrement_ch,
  input  logic [count_sz-1:0] maybeDecrement_v,
  output logic                maybeDecrement,
  output logic                maybeDecrement__RDY,
  input  logic                setLimit__ENA,
  input  logic [ch_sz-1:0]    setLimit_ch,
  input  logic [count_sz-1:0] setLimit_v,
  output logic                setLimit__RDY,
  input  logic                clearErr__ENA,
  input  logic [ch_sz-1:0]    read_ch,
  output logic [count_sz-1:0] read,
  output logic                read__RDY,
  output logic [num_ch-1:0]   positive,
  output logic [num_ch-1:0]   atLimit,
  output logic [num_ch-1:0]   overflow,
  output logic [num_ch-1:0]   underflow
);

  // Handshake: every method is always ready (__RDY held at 1), so a command
  // fires on exactly the cycles its __ENA is high; no backpressure exists.
  assign increment__RDY      = 1'b1;
  assign decrement__RDY      = 1'b1;
  assign maybeDecrement__RDY = 1'b1;
  assign setLimit__RDY       = 1'b1;
  assign read__RDY           = 1'b1;

  // Two extra bits hold the sum of two counts and the negative dip of two subtractions.
  localparam int W = count_sz + 2;
  localparam logic signed [W-1:0] ZERO = '0;
  localparam logic [ch_sz:0] NUM_CH_W = (ch_sz+1)'(num_ch);

  logic [count_sz-1:0] cnt_view [num_ch];
  logic [num_ch-1:0]   acc_view;

  for (genvar g = 0; g < num_ch; g++) begin : g_ch
    localparam logic [ch_sz-1:0] IDX = ch_sz'(g);

    logic                inc_hit, dec_hit, mv_hit, lim_hit;
    logic [count_sz-1:0] cnt_q, lim_q, cnt_d, lim_d;
    logic signed [W-1:0] cur, inc_s, dec_s, mv_s, lim_s, raw;
    logic                acc, of_set, uf_set;
    logic                pos_q, of_q, uf_q;

    assign inc_hit = increment__ENA      && (increment_ch      == IDX);
    assign dec_hit = decrement__ENA      && (decrement_ch      == IDX);
    assign mv_hit  = maybeDecrement__ENA && (maybeDecrement_ch == IDX);
    assign lim_hit = setLimit__ENA       && (setLimit_ch       == IDX);

    always_comb begin
      cur    = $signed({2'b00, cnt_q});
      inc_s  = inc_hit ? $signed({2'b00, increment_v})      : ZERO;
      dec_s  = dec_hit ? $signed({2'b00, decrement_v})      : ZERO;
      mv_s   = mv_hit  ? $signed({2'b00, maybeDecrement_v}) : ZERO;
      lim_d  = lim_hit ? setLimit_v : lim_q;
      lim_s  = $signed({2'b00, lim_d});
      // Acceptance ignores the same-cycle increment so a consumer never
      // spends credit that is only arriving this cycle.
      acc    = (cur - dec_s) >= mv_s;
      raw    = cur + inc_s - dec_s - (acc ? mv_s : ZERO);
      cnt_d  = raw[count_sz-1:0];
      of_set = 1'b0;
      uf_set = 1'b0;
      if (raw[W-1]) begin
        cnt_d  = '0;
        uf_set = 1'b1;
      end else if (raw > lim_s) begin
        cnt_d  = lim_d;
        of_set = inc_hit && (increment_v != '0);
      end
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        cnt_q <= '0;
        lim_q <= '1;
        pos_q <= 1'b0;
        of_q  <= 1'b0;
        uf_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lim_q <= lim_d;
        pos_q <= (cnt_d != '0);
        of_q  <= of_set | (of_q & ~clearErr__ENA);
        uf_q  <= uf_set | (uf_q & ~clearErr__ENA);
      end
    end

    assign cnt_view[g]  = cnt_q;
    assign acc_view[g]  = acc;
    assign positive[g]  = pos_q;
    assign atLimit[g]   = (cnt_q == lim_q);
    assign overflow[g]  = of_q;
    assign underflow[g] = uf_q;
  end

  always_comb begin
    read = '0;
    if ({1'b0, read_ch} < NUM_CH_W) read = cnt_view[read_ch];
  end

  always_comb begin
    maybeDecrement = 1'b0;
    if (maybeDecrement__ENA && ({1'b0, maybeDecrement_ch} < NUM_CH_W))
      maybeDecrement = acc_view[maybeDecrement_ch];
  end

endmodule

// File: tb/tb_multi_config_counter.sv
// Bench for multi_config_counter: directed scenarios plus random traffic,
// checked against a small behavioural model through an expected-value queue.
module tb_multi_config_counter;

  localparam int CW = 10;
  localparam int NC = 4;
  localparam int CS = 3;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          inc_en, dec_en, mv_en, sl_en, clr;
  logic [CS-1:0] inc_ch, dec_ch, mv_ch, sl_ch, rd_ch;
  logic [CW-1:0] inc_v, dec_v, mv_v, sl_v;
  logic          inc_rdy, dec_rdy, mv_rdy, sl_rdy, rd_rdy, mv_ok;
  logic [CW-1:0] rd_val;
  logic [NC-1:0] positive, at_limit, overflow, underflow;

  multi_config_counter #(.count_sz(CW), .num_ch(NC), .ch_sz(CS)) dut (
    .CLK(CLK), .nRST(nRST),
    .increment__ENA(inc_en), .increment_ch(inc_ch), .increment_v(inc_v), .increment__RDY(inc_rdy),
    .decrement__ENA(dec_en), .decrement_ch(dec_ch), .decrement_v(dec_v), .decrement__RDY(dec_rdy),
    .maybeDecrement__ENA(mv_en), .maybeDecrement_ch(mv_ch), .maybeDecrement_v(mv_v),
    .maybeDecrement(mv_ok), .maybeDecrement__RDY(mv_rdy),
    .setLimit__ENA(sl_en), .setLimit_ch(sl_ch), .setLimit_v(sl_v), .setLimit__RDY(sl_rdy),
    .clearErr__ENA(clr), .read_ch(rd_ch), .read(rd_val), .read__RDY(rd_rdy),
    .positive(positive), .atLimit(at_limit), .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  always #10 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int            m_cnt [NC];
  int            m_lim [NC];
  logic [NC-1:0] m_of, m_uf;
  logic [15:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            seen_cnt [NC];
  logic          mv_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    inc_en = 0; dec_en = 0; mv_en = 0; sl_en = 0; clr = 0;
    inc_ch = 0; dec_ch = 0; mv_ch = 0; sl_ch = 0;
    inc_v = 0; dec_v = 0; mv_v = 0; sl_v = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_lim[i] = (1 << CW) - 1;
    end
    m_of = '0;
    m_uf = '0;
  endtask

  // Counts and flag vectors after an edge, compared in the order pushed.
  task automatic verify_state();
    for (int i = 0; i < NC; i++) begin
      rd_ch = CS'(i);
      #1;
      seen_cnt[i] = int'(rd_val);
      check($sformatf("read_ch%0d", i), 32'(rd_val), 32'(exp_q.pop_front()));
    end
    check("positive",  32'(positive),  32'(exp_q.pop_front()));
    check("atLimit",   32'(at_limit),  32'(exp_q.pop_front()));
    check("overflow",  32'(overflow),  32'(exp_q.pop_front()));
    check("underflow", 32'(underflow), 32'(exp_q.pop_front()));
    rd_ch = 3'd5;
    #1;
    check("read_oob", 32'(rd_val), 32'd0);
  endtask

  // Called just after the negedge with inputs driven; advances one clock.
  task automatic step();
    int            inc, dec, mv, lim, raw;
    int            exp_mv;
    logic [NC-1:0] pos_e, atl_e, of_set, uf_set;
    logic [NC-1:0] acc;
    exp_mv = 0;
    of_set = '0;
    uf_set = '0;
    for (int i = 0; i < NC; i++) begin
      inc = (inc_en && inc_ch == CS'(i)) ? int'(inc_v) : 0;
      dec = (dec_en && dec_ch == CS'(i)) ? int'(dec_v) : 0;
      mv  = (mv_en  && mv_ch  == CS'(i)) ? int'(mv_v)  : 0;
      lim = (sl_en  && sl_ch  == CS'(i)) ? int'(sl_v)  : m_lim[i];
      acc[i] = (m_cnt[i] - dec >= mv);
      raw = m_cnt[i] + inc - dec - (acc[i] ? mv : 0);
      if (raw < 0) begin
        m_cnt[i] = 0;
        uf_set[i] = 1'b1;
      end else if (raw > lim) begin
        m_cnt[i] = lim;
        of_set[i] = (inc != 0);
      end else begin
        m_cnt[i] = raw;
      end
      m_lim[i] = lim;
      pos_e[i] = (m_cnt[i] != 0);
      atl_e[i] = (m_cnt[i] == m_lim[i]);
    end
    if (mv_en && int'(mv_ch) < NC) exp_mv = int'(acc[mv_ch]);
    m_of = of_set | (m_of & ~{NC{clr}});
    m_uf = uf_set | (m_uf & ~{NC{clr}});
    for (int i = 0; i < NC; i++) exp_q.push_back(16'(m_cnt[i]));
    exp_q.push_back(16'(pos_e));
    exp_q.push_back(16'(atl_e));
    exp_q.push_back(16'(m_of));
    exp_q.push_back(16'(m_uf));
    #1;
    mv_seen = mv_ok;
    if (mv_en) check("maybeDecrement", 32'(mv_ok), 32'(exp_mv));
    @(posedge CLK);
    #1;
    idle();
    verify_state();
    @(negedge CLK);
  endtask

  // driver helpers
  task automatic do_inc(input int ch, input int v);
    inc_en = 1; inc_ch = CS'(ch); inc_v = CW'(v); step();
  endtask

  task automatic do_dec(input int ch, input int v);
    dec_en = 1; dec_ch = CS'(ch); dec_v = CW'(v); step();
  endtask

  task automatic do_mv(input int ch, input int v);
    mv_en = 1; mv_ch = CS'(ch); mv_v = CW'(v); step();
  endtask

  task automatic do_lim(input int ch, input int v);
    sl_en = 1; sl_ch = CS'(ch); sl_v = CW'(v); step();
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NC; i++) begin
      rd_ch = CS'(i);
      #1;
      check($sformatf("%s_read_ch%0d", tag, i), 32'(rd_val), 32'd0);
    end
    check({tag, "_positive"},  32'(positive),  32'd0);
    check({tag, "_atLimit"},   32'(at_limit),  32'd0);
    check({tag, "_overflow"},  32'(overflow),  32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    idle();
    rd_ch = 0;
    nRST = 1'b0;
    model_reset();
    #25;
    check_reset_state("reset");
    check("rdy_all", 32'({inc_rdy, dec_rdy, mv_rdy, sl_rdy, rd_rdy}), 32'h1f);
    @(negedge CLK);
    nRST = 1'b1;

    // single increment, then asynchronous mid-run reset
    do_inc(1, 5);
    check("tp_inc_ch1", 32'(seen_cnt[1]), 32'd5);
    check("tp_positive", 32'(positive), 32'b0010);
    do_inc(2, 7);
    #3;
    nRST = 1'b0;
    #1;
    model_reset();
    check_reset_state("midreset");
    @(negedge CLK);
    nRST = 1'b1;

    // conditional decrement reject / accept
    do_inc(0, 3);
    do_mv(0, 4);
    check("tp_mv_reject", 32'(mv_seen), 32'd0);
    check("tp_mv_reject_cnt", 32'(seen_cnt[0]), 32'd3);
    do_mv(0, 3);
    check("tp_mv_accept", 32'(mv_seen), 32'd1);
    check("tp_mv_accept_pos", 32'(positive[0]), 32'd0);

    // decrement and maybeDecrement in the same cycle
    do_inc(2, 10);
    dec_en = 1; dec_ch = 2; dec_v = 6; mv_en = 1; mv_ch = 2; mv_v = 5; step();
    check("tp_same_cycle_rej", 32'(mv_seen), 32'd0);
    check("tp_same_cycle_rej_cnt", 32'(seen_cnt[2]), 32'd4);
    do_inc(2, 6);
    dec_en = 1; dec_ch = 2; dec_v = 6; mv_en = 1; mv_ch = 2; mv_v = 4; step();
    check("tp_same_cycle_acc", 32'(mv_seen), 32'd1);
    check("tp_same_cycle_acc_cnt", 32'(seen_cnt[2]), 32'd0);

    // saturation at a programmed limit and sticky overflow
    do_lim(3, 8);
    do_inc(3, 12);
    check("tp_sat_cnt", 32'(seen_cnt[3]), 32'd8);
    check("tp_sat_flag", 32'(overflow[3]), 32'd1);
    check("tp_sat_atlimit", 32'(at_limit[3]), 32'd1);
    clr = 1; step();
    check("tp_clear", 32'(overflow), 32'd0);
    clr = 1; inc_en = 1; inc_ch = 3; inc_v = 1; step();
    check("tp_set_beats_clear", 32'(overflow[3]), 32'd1);

    // lowered limit clamps without a flag; underflow clamp
    do_inc(1, 20);
    do_lim(1, 7);
    check("tp_lower_limit_cnt", 32'(seen_cnt[1]), 32'd7);
    check("tp_lower_limit_flag", 32'(overflow[1]), 32'd0);
    do_dec(1, 9);
    check("tp_underflow_cnt", 32'(seen_cnt[1]), 32'd0);
    check("tp_underflow_flag", 32'(underflow[1]), 32'd1);

    // out-of-range channel commands
    inc_en = 1; inc_ch = 5; inc_v = 9; dec_en = 1; dec_ch = 5; dec_v = 1;
    mv_en = 1; mv_ch = 5; mv_v = 0; sl_en = 1; sl_ch = 5; sl_v = 2; step();
    check("tp_oob_mv", 32'(mv_seen), 32'd0);

    // full-scale increment clamps at the reset limit
    clr = 1; step();
    do_inc(0, 1023);
    check("tp_max_cnt", 32'(seen_cnt[0]), 32'd1023);
    do_inc(0, 1023);
    check("tp_max_nowrap", 32'(seen_cnt[0]), 32'd1023);
    check("tp_max_flag", 32'(overflow[0]), 32'd1);

    // random traffic on all commands, channels 0..5
    for (int n = 0; n < 80; n++) begin
      inc_en = ($urandom_range(0, 1) == 1); inc_ch = CS'($urandom_range(0, 5));
      inc_v  = CW'($urandom_range(0, 40));
      dec_en = ($urandom_range(0, 2) == 0); dec_ch = CS'($urandom_range(0, 5));
      dec_v  = CW'($urandom_range(0, 30));
      mv_en  = ($urandom_range(0, 1) == 1); mv_ch = CS'($urandom_range(0, 5));
      mv_v   = CW'($urandom_range(0, 30));
      sl_en  = ($urandom_range(0, 7) == 0); sl_ch = CS'($urandom_range(0, 5));
      sl_v   = CW'($urandom_range(10, 80));
      clr    = ($urandom_range(0, 9) == 0);
      step();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_config_counter.md
Name: multi_config_counter

Overview:
Multi-channel successor to the single-channel config counter. It holds num_ch independent credit/occupancy counters, each with a programmable saturation limit, a conditional decrement and sticky overflow/underflow flags. It sits between producers (increment) and consumers (decrement / maybeDecrement) in flow-control paths where several queues share one credit manager.

Parameters:
count_sz, 10, width of each counter and limit
num_ch, 4, number of channels
ch_sz, 2, width of channel-select fields (2^ch_sz >= num_ch)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
increment__ENA  input  1  add increment$v to channel increment$ch
increment$ch  input  ch_sz  channel select
increment$v  input  count_sz  amount to add
increment__RDY  output  1  constant 1
decrement__ENA  input  1  unconditional subtract
decrement$ch  input  ch_sz  channel select
decrement$v  input  count_sz  amount to subtract
decrement__RDY  output  1  constant 1
maybeDecrement__ENA  input  1  conditional subtract
maybeDecrement$ch  input  ch_sz  channel select
maybeDecrement$v  input  count_sz  amount to subtract
maybeDecrement  output  1  1 = conditional subtract accepted (combinational)
maybeDecrement__RDY  output  1  constant 1
setLimit__ENA  input  1  load new limit
setLimit$ch  input  ch_sz  channel select
setLimit$v  input  count_sz  new limit
setLimit__RDY  output  1  constant 1
clearErr__ENA  input  1  clear all sticky flags
read$ch  input  ch_sz  read channel select
read  output  count_sz  count of read$ch (combinational)
read__RDY  output  1  constant 1
positive  output  num_ch  registered, count > 0 per channel
atLimit  output  num_ch  count == limit per channel (combinational from registers)
overflow  output  num_ch  sticky: increment clamped at limit
underflow  output  num_ch  sticky: decrement clamped at 0

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous and active-low.
- Reset, asynchronous and immediate: cnt[i]=0, limit[i]=2^count_sz-1, positive=0, overflow=0, underflow=0. Mid-operation reset discards any in-flight update. First update is on the first CLK edge after nRST deasserts.
- All __RDY are tied to 1. All four commands may fire in the same cycle, on the same or different channels.
- A command with channel >= num_ch is ignored. In that case maybeDecrement=0 and read=0.
- Per channel i, per cycle, with signed arithmetic at count_sz+2 bits:
  - inc = increment$v if the increment targets i, else 0; dec and mv likewise for decrement and maybeDecrement.
  - lim = setLimit$v if setLimit targets i this cycle, else limit[i].
  - Accept: acc = (cnt[i] - dec >= mv). maybeDecrement = acc for the addressed channel. It is computed on the current cnt and never includes the same-cycle increment.
  - Sum: raw = cnt[i] + inc - dec - (acc ? mv : 0).
  - raw < 0: cnt <= 0; underflow[i] set.
  - raw > lim: cnt <= lim; overflow[i] set only if inc != 0. Clamping caused only by a lowered limit sets no flag.
  - Otherwise cnt <= raw.
- limit[i] <= setLimit$v takes effect at the edge. The new limit also clamps in that same cycle.
- positive[i] <= (next cnt[i] != 0), i.e. registered alongside cnt.
- clearErr clears both sticky vectors at the edge. A same-cycle set on a channel wins over the clear for that channel.
- Latency: read, atLimit and maybeDecrement are combinational. Count and positive update 1 cycle after a command.

Test Plan:
- Reset then inc ch1 by 5, then read ch1 -> read=5 next cycle; positive=4'b0010; others 0. Assert nRST mid-run -> all state zero immediately, limits all-ones.
- cnt ch0=3; maybeDecrement ch0 v=4 -> maybeDecrement=0, cnt stays 3. v=3 -> maybeDecrement=1, cnt=0, positive[0]=0.
- Same cycle on ch2 (cnt=10): decrement 6 and maybeDecrement 5 -> acc=0, cnt=4. Same again with maybeDecrement 4 -> acc=1, cnt=0.
- setLimit ch3=8, then inc ch3 by 12 -> cnt=8, atLimit[3]=1, overflow[3]=1. clearErr -> overflow=0. clearErr and overflowing inc together -> flag stays 1.
- cnt ch1=20; setLimit ch1=7 with no inc -> cnt=7, overflow[1]=0. decrement ch1 by 9 -> cnt=0, underflow[1]=1.
- Commands and read on ch index 5 with num_ch=4, ch_sz=3 -> no state change, read=0, maybeDecrement=0. inc ch0 by max with count_sz=10 -> clamps at 1023, no wrap.
